// File: rtl/sum_result_buffer.sv
// -----------------------------------------------------------------------------
// sum_result_buffer
//
// Small synchronous FIFO that buffers results coming out of an upstream adder.
// The adder cannot be stalled, so a result arriving while the buffer is full
// (and nothing leaves in the same cycle) is dropped and recorded in a sticky
// overflow flag. An optional running sum of every result that leaves the
// buffer is provided on acc.
//
// Build option:
//   SUM_RESULT_BUFFER_ACC_EN - when defined, acc accumulates every popped word
//                              (modulo 2^(W+8)); when undefined, acc is a
//                              constant 0 and no accumulator register exists.
//
// Parameters:
//   W      - data width, equal to the upstream adder result width
//   DEPTH  - number of entries, power of two, >= 2
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream result strobe (no backpressure available)
//   in_data    upstream result, sampled when in_valid=1
//   out_valid  head entry available
//   out_ready  downstream accepts the head entry
//   out_data   head entry (don't-care while empty)
//   count      occupancy 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: at least one result was dropped
//   clr_ovf    clears overflow (a drop in the same cycle wins)
//   acc        running sum of popped results
// -----------------------------------------------------------------------------
module sum_result_buffer #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [W+7:0]             acc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE_C   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE_C   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO_C  = CW'(1'b0);
    localparam logic [CW-1:0] CNT_FULL_C  = CW'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          overflow_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;

    // Status flags and handshake qualification derived from registered state.
    always_comb begin
        full_s  = (count_r == CNT_FULL_C);
        empty_s = (count_r == CNT_ZERO_C);
        pop_s   = !empty_s && out_ready;
        // A pop in the same cycle frees the slot, so a full buffer still accepts.
        push_s  = in_valid && (!full_s || pop_s);
        drop_s  = in_valid && full_s && !pop_s;
    end

    // Next occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_nxt_s;
        end
    end

    // Storage array; contents need no reset since out_data is ignored when empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Sticky overflow; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end
    end

`ifdef SUM_RESULT_BUFFER_ACC_EN
    logic [W+7:0] acc_r;

    // Running sum of every word that leaves the buffer, wrapping at 2^(W+8).
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (pop_s) begin
            acc_r <= acc_r + {8'h00, mem_r[rd_ptr_r]};
        end
    end

    assign acc = acc_r;
`else
    assign acc = {(W+8){1'b0}};
`endif

    assign out_valid = !empty_s;
    assign out_data  = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_sum_result_buffer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for sum_result_buffer (W=16, DEPTH=4).
// Inputs change 1 ns after the rising edge; outputs are sampled at that same
// point, i.e. well away from the active edge.
// -----------------------------------------------------------------------------
module tb_sum_result_buffer;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          clr_ovf;
    logic [W+7:0]  acc;

    int checks;
    int errors;

    sum_result_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_data = 16'h0000;
        do_reset();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || empty !== 1'b1 ||
            full !== 1'b0 || overflow !== 1'b0 || acc !== 24'h000000) begin
            $display("FAIL reset_state: count=%0d out_valid=%b empty=%b full=%b overflow=%b acc=%h, required 0 0 1 0 0 000000",
                     count, out_valid, empty, full, overflow, acc);
            errors++;
        end
    endtask

    task automatic test_order();
        logic [15:0] exp [3];
        exp = '{16'h0003, 16'h0005, 16'h0007};
        do_reset();
        in_valid = 1'b1; in_data = exp[0];
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL no_fallthrough_before: out_valid=%b required 0", out_valid);
            errors++;
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL no_fallthrough_after: out_valid=%b required 1", out_valid);
            errors++;
        end
        in_data = exp[1]; tick();
        in_data = exp[2]; tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            $display("FAIL order_count: count=%0d required 3", count);
            errors++;
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0003 || count !== 3'd3) begin
            $display("FAIL stall_stable: out_valid=%b out_data=%h count=%0d required 1 0003 3",
                     out_valid, out_data, count);
            errors++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                $display("FAIL order_pop%0d: out_valid=%b out_data=%h required 1 %h",
                         i, out_valid, out_data, exp[i]);
                errors++;
            end
            tick();
        end
        checks++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            $display("FAIL order_empty: empty=%b count=%0d required 1 0", empty, count);
            errors++;
        end
        // out_ready while empty must be ignored
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            $display("FAIL ready_when_empty: count=%0d out_valid=%b required 0 0", count, out_valid);
            errors++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'hA000 + 16'(i);
            tick();
        end
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
            $display("FAIL ovf_full: full=%b count=%0d overflow=%b required 1 4 0", full, count, overflow);
            errors++;
        end
        in_data = 16'hA004; tick();
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            $display("FAIL ovf_drop: overflow=%b count=%0d required 1 4", overflow, count);
            errors++;
        end
        // clear and a new drop in the same cycle: overflow must stay set
        in_valid = 1'b1; in_data = 16'hA005; clr_ovf = 1'b1;
        tick();
        in_valid = 1'b0; clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            $display("FAIL ovf_clr_vs_drop: overflow=%b count=%0d required 1 4", overflow, count);
            errors++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'hA000 + 16'(i)) begin
                $display("FAIL ovf_pop%0d: out_valid=%b out_data=%h required 1 %h",
                         i, out_valid, out_data, 16'hA000 + 16'(i));
                errors++;
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            $display("FAIL ovf_sticky: empty=%b overflow=%b required 1 1", empty, overflow);
            errors++;
        end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            $display("FAIL ovf_clear: overflow=%b required 0", overflow);
            errors++;
        end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'hB000 + 16'(i);
            tick();
        end
        in_data = 16'hB004; out_ready = 1'b1;
        checks++;
        if (out_data !== 16'hB000 || full !== 1'b1) begin
            $display("FAIL full_pp_head: out_data=%h full=%b required B000 1", out_data, full);
            errors++;
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || overflow !== 1'b0) begin
            $display("FAIL full_pp_count: count=%0d overflow=%b required 4 0", count, overflow);
            errors++;
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'hB000 + 16'(i)) begin
                $display("FAIL full_pp_pop%0d: out_valid=%b out_data=%h required 1 %h",
                         i, out_valid, out_data, 16'hB000 + 16'(i));
                errors++;
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            $display("FAIL full_pp_empty: empty=%b required 1", empty);
            errors++;
        end
    endtask

    task automatic test_wrap();
        // op per cycle: 0 = push only, 1 = pop only, 2 = push and pop
        int          ops [13];
        logic [15:0] q [$];
        logic [15:0] next_val;
        ops = '{0, 1, 1, 2, 0, 0, 2, 1, 1, 0, 2, 1, 1};
        next_val = 16'h1000;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = next_val; q.push_back(next_val); next_val++;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            in_valid  = (ops[i] != 1);
            out_ready = (ops[i] != 0);
            in_data   = next_val;
            if (out_ready) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== q[0]) begin
                    $display("FAIL wrap_pop%0d: out_valid=%b out_data=%h required 1 %h",
                             i, out_valid, out_data, q[0]);
                    errors++;
                end
                void'(q.pop_front());
            end
            if (in_valid) begin
                q.push_back(next_val); next_val++;
            end
            tick();
            checks++;
            if (count !== 3'(q.size())) begin
                $display("FAIL wrap_count%0d: count=%0d required %0d", i, count, q.size());
                errors++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'hC000 + 16'(i);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd2 || overflow !== 1'b1) begin
            $display("FAIL mid_pre: count=%0d overflow=%b required 2 1", count, overflow);
            errors++;
        end
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || acc !== 24'h000000) begin
            $display("FAIL mid_reset: count=%0d out_valid=%b overflow=%b acc=%h required 0 0 0 000000",
                     count, out_valid, overflow, acc);
            errors++;
        end
        in_valid = 1'b1; in_data = 16'h00AA;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || out_valid !== 1'b1 || out_data !== 16'h00AA) begin
            $display("FAIL mid_after: count=%0d out_valid=%b out_data=%h required 1 1 00AA",
                     count, out_valid, out_data);
            errors++;
        end
    endtask

    task automatic test_acc();
        logic [23:0] exp_acc;
`ifdef SUM_RESULT_BUFFER_ACC_EN
        exp_acc = 24'h010001;
`else
        exp_acc = 24'h000000;
`endif
        do_reset();
        in_valid = 1'b1;
        in_data = 16'hFFFF; tick();
        in_data = 16'h0002; tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        checks++;
        if (acc !== exp_acc || empty !== 1'b1) begin
            $display("FAIL acc_sum: acc=%h empty=%b required %h 1", acc, empty, exp_acc);
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000;
        out_ready = 1'b0; clr_ovf = 1'b0;
        #1;
        test_reset();
        test_order();
        test_overflow();
        test_push_pop_full();
        test_wrap();
        test_reset_mid();
        test_acc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
